// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the direct-mapped write-back cache datapath.
// Samples controller requests, evaluates hit/dirty, runs block write-back and
// refill handshakes with the backing memory, and commits writes.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module cache_control #(
    parameter int COUNTER_SIZE = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic ctrl_en,
    output logic ctrl_busy,
    output logic mem_en,
    output logic mem_wr_en,
    input  logic mem_ack,
    output logic sample_ctrl_inputs,
    output logic set_valid,
    output logic set_tag,
    output logic set_data,
    output logic set_dirty,
    input  logic ctrl_wr_en_d,
    input  logic hit,
    input  logic dirty
`ifdef CACHE_STATS_EN
    ,
    output logic [COUNTER_SIZE-1:0] hit_count,
    output logic [COUNTER_SIZE-1:0] miss_count,
    output logic [COUNTER_SIZE-1:0] writeback_count
`endif
);

    if (COUNTER_SIZE < 1) begin : g_bad_counter_size
        $error("COUNTER_SIZE must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // State register; synchronous reset returns to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; everything is held at 0 while reset is high.
    always_comb begin
        state_d            = state_q;
        ctrl_busy          = 1'b0;
        mem_en             = 1'b0;
        mem_wr_en          = 1'b0;
        sample_ctrl_inputs = 1'b0;
        set_valid          = 1'b0;
        set_tag            = 1'b0;
        set_data           = 1'b0;
        set_dirty          = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    sample_ctrl_inputs = ctrl_en;
                    if (ctrl_en) begin
                        state_d = COMPARE;
                    end
                end
                COMPARE: begin
                    ctrl_busy = 1'b1;
                    if (hit) begin
                        if (ctrl_wr_en_d) begin
                            set_data  = 1'b1;
                            set_dirty = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (dirty) begin
                        state_d = WRITE_BACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    ctrl_busy = 1'b1;
                    mem_en    = 1'b1;
                    mem_wr_en = 1'b1;
                    if (mem_ack) begin
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    ctrl_busy = 1'b1;
                    mem_en    = 1'b1;
                    if (mem_ack) begin
                        set_data  = 1'b1;
                        set_valid = 1'b1;
                        set_tag   = 1'b1;
                        state_d   = COMPARE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [COUNTER_SIZE-1:0] hit_cnt_q, hit_cnt_d;
    logic [COUNTER_SIZE-1:0] miss_cnt_q, miss_cnt_d;
    logic [COUNTER_SIZE-1:0] wb_cnt_q, wb_cnt_d;
    logic                    refill_q, refill_d;

    // Saturating counter updates; the refill flag keeps the post-refill
    // re-compare from being counted as a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        refill_d   = refill_q;
        case (state_q)
            COMPARE: begin
                refill_d = 1'b0;
                if (hit) begin
                    if (!refill_q && (hit_cnt_q != '1)) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end else if (miss_cnt_q != '1) begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
            WRITE_BACK: begin
                if (mem_ack && (wb_cnt_q != '1)) begin
                    wb_cnt_d = wb_cnt_q + 1'b1;
                end
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    refill_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
            refill_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
            refill_q   <= refill_d;
        end
    end

    // Counter outputs are forced to 0 while reset is high.
    always_comb begin
        hit_count       = reset ? '0 : hit_cnt_q;
        miss_count      = reset ? '0 : miss_cnt_q;
        writeback_count = reset ? '0 : wb_cnt_q;
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: the driver pushes the hand-computed
// per-cycle output vector, a negedge monitor pops and compares it.
module tb_cache_control;

    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ctrl_en = 1'b0;
    logic mem_ack = 1'b0;
    logic ctrl_wr_en_d = 1'b0;
    logic hit = 1'b0;
    logic dirty = 1'b0;
    logic ctrl_busy, mem_en, mem_wr_en, sample_ctrl_inputs;
    logic set_valid, set_tag, set_data, set_dirty;
`ifdef CACHE_STATS_EN
    logic [CW-1:0] hit_count, miss_count, writeback_count;
`endif

    always #5 clock = ~clock;

    cache_control #(.COUNTER_SIZE(CW)) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_en(ctrl_en),
        .ctrl_busy(ctrl_busy),
        .mem_en(mem_en),
        .mem_wr_en(mem_wr_en),
        .mem_ack(mem_ack),
        .sample_ctrl_inputs(sample_ctrl_inputs),
        .set_valid(set_valid),
        .set_tag(set_tag),
        .set_data(set_data),
        .set_dirty(set_dirty),
        .ctrl_wr_en_d(ctrl_wr_en_d),
        .hit(hit),
        .dirty(dirty)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count),
        .writeback_count(writeback_count)
`endif
    );

    typedef struct {
        string       name;
        logic [7:0]  o;
        bit          chk;
        int unsigned h;
        int unsigned m;
        int unsigned w;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int unsigned eh = 0, em = 0, ew = 0;

    // Output vector order: busy, mem_en, mem_wr_en, sample, valid, tag, data, dirty
    task automatic step(input string nm, input bit rst, input bit en, input bit wr,
                        input bit h, input bit d, input bit ack,
                        input logic [7:0] o, input bit chk);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst;
        ctrl_en = en;
        ctrl_wr_en_d = wr;
        hit = h;
        dirty = d;
        mem_ack = ack;
        e.name = nm;
        e.o = o;
        e.chk = chk;
        e.h = eh;
        e.m = em;
        e.w = ew;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic [7:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {ctrl_busy, mem_en, mem_wr_en, sample_ctrl_inputs,
                   set_valid, set_tag, set_data, set_dirty};
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL %s outputs got %b want %b", e.name, act, e.o);
            end
`ifdef CACHE_STATS_EN
            if (e.chk) begin
                checks++;
                if (hit_count !== CW'(e.h) || miss_count !== CW'(e.m) ||
                    writeback_count !== CW'(e.w)) begin
                    errors++;
                    $display("FAIL %s counters got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                             e.name, hit_count, miss_count, writeback_count, e.h, e.m, e.w);
                end
            end
`endif
        end
    end

    initial begin
        // reset, with a request strobe that must be masked
        step("reset0", 1, 1, 0, 0, 0, 0, 8'b0000_0000, 1);
        step("reset1", 1, 1, 0, 0, 0, 1, 8'b0000_0000, 1);
        step("idle0",  0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // read hit, stray ack in COMPARE
        step("rh_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("rh_cmp",  0, 0, 0, 1, 0, 1, 8'b1000_0000, 0);
        eh = 1;
        step("rh_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // write hit
        step("wh_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("wh_cmp",  0, 0, 1, 1, 0, 0, 8'b1000_0011, 0);
        eh = 2;
        step("wh_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // clean read miss, three wait cycles then ack
        step("cm_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("cm_cmp",  0, 0, 0, 0, 0, 0, 8'b1000_0000, 0);
        em = 1;
        step("cm_al0",  0, 0, 0, 0, 0, 0, 8'b1100_0000, 1);
        step("cm_al1",  0, 0, 0, 0, 0, 0, 8'b1100_0000, 1);
        step("cm_al2",  0, 0, 0, 0, 0, 0, 8'b1100_0000, 1);
        step("cm_ack",  0, 0, 0, 0, 0, 1, 8'b1100_1110, 1);
        step("cm_rcmp", 0, 0, 0, 1, 0, 0, 8'b1000_0000, 0);
        step("cm_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // dirty write miss
        step("dm_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("dm_cmp",  0, 0, 1, 0, 1, 0, 8'b1000_0000, 0);
        em = 2;
        step("dm_wb0",  0, 0, 1, 0, 1, 0, 8'b1110_0000, 1);
        step("dm_wbak", 0, 0, 1, 0, 1, 1, 8'b1110_0000, 1);
        ew = 1;
        step("dm_alak", 0, 0, 1, 0, 0, 1, 8'b1100_1110, 1);
        step("dm_rcmp", 0, 0, 1, 1, 0, 0, 8'b1000_0011, 0);
        step("dm_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // stray ack in IDLE, then ctrl_en held through a whole miss
        step("ig_ack",  0, 0, 0, 0, 0, 1, 8'b0000_0000, 0);
        step("ig_idle", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);
        step("ig_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("ig_cmp",  0, 1, 0, 0, 0, 0, 8'b1000_0000, 0);
        em = 3;
        step("ig_alak", 0, 1, 0, 0, 0, 1, 8'b1100_1110, 1);
        step("ig_rcmp", 0, 1, 0, 1, 0, 0, 8'b1000_0000, 0);
        step("ig_req2", 0, 1, 0, 0, 0, 0, 8'b0001_0000, 1);
        step("ig_cmp2", 0, 0, 0, 1, 0, 0, 8'b1000_0000, 0);
        eh = 3;
        step("ig_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // counters saturate at all-ones
        step("sat_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("sat_cmp",  0, 0, 0, 1, 0, 0, 8'b1000_0000, 0);
        step("sat_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // reset in the middle of ALLOCATE
        step("rs_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("rs_cmp",  0, 0, 0, 0, 0, 0, 8'b1000_0000, 0);
        step("rs_al0",  0, 0, 0, 0, 0, 0, 8'b1100_0000, 1);
        eh = 0;
        em = 0;
        ew = 0;
        step("rs_rst",  1, 1, 0, 0, 0, 1, 8'b0000_0000, 1);
        step("rs_idle", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        // normal operation after reset
        step("pr_req",  0, 1, 0, 0, 0, 0, 8'b0001_0000, 0);
        step("pr_cmp",  0, 0, 0, 1, 0, 0, 8'b1000_0000, 0);
        eh = 1;
        step("pr_done", 0, 0, 0, 0, 0, 0, 8'b0000_0000, 1);

        @(posedge clock);
        @(posedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the direct-mapped, write-back cache datapath (`cache_path`). It accepts single-word requests from the memory controller and samples them into the datapath. It evaluates hit/dirty, performs block write-back and refill through a request/acknowledge handshake with the backing memory, and commits writes.

## Interface
Parameters:
- `COUNTER_SIZE`, default 32: width of each statistics counter; only used with `CACHE_STATS_EN`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ctrl_en` in 1: request strobe from the controller.
- `ctrl_busy` out 1: high while a request is in progress.
- `mem_en` out 1: backing-memory access request, held until acknowledged.
- `mem_wr_en` out 1: the access is a block write. Valid only while `mem_en` is high.
- `mem_ack` in 1: one-cycle completion pulse from the backing memory.
- `sample_ctrl_inputs` out 1: datapath latches the controller address, data and write enable.
- `set_valid`, `set_tag`, `set_data`, `set_dirty` out 1 each: datapath update strobes.
- `ctrl_wr_en_d` in 1: registered write flag from the datapath.
- `hit` in 1: datapath hit indication.
- `dirty` in 1: datapath dirty indication.
- `hit_count`, `miss_count`, `writeback_count` out `COUNTER_SIZE` each: statistics counters, present only with `CACHE_STATS_EN`.

## Operation
States are IDLE, COMPARE, WRITE_BACK and ALLOCATE.
- **IDLE**
  - `ctrl_busy` is 0 and `sample_ctrl_inputs` equals `ctrl_en`.
  - If `ctrl_en` is high, go to COMPARE.
- **COMPARE** (`hit`/`dirty` reflect the sampled address)
  - Hit and `ctrl_wr_en_d`=0: go to IDLE. Read data is valid from the first IDLE cycle until the next accepted request.
  - Hit and `ctrl_wr_en_d`=1: assert `set_data`=1 and `set_dirty`=1 for one cycle, then go to IDLE.
  - Miss and `dirty`=1: go to WRITE_BACK.
  - Miss and `dirty`=0: go to ALLOCATE.
- **WRITE_BACK**
  - `mem_en`=1 and `mem_wr_en`=1.
  - On `mem_ack`, go to ALLOCATE.
- **ALLOCATE**
  - `mem_en`=1 and `mem_wr_en`=0.
  - On `mem_ack`, assert `set_data`, `set_valid` and `set_tag` with `set_dirty`=0 in that same cycle, then go to COMPARE.
  - The re-compare is guaranteed to hit. A write miss is therefore committed in the second COMPARE.
- **Output rules**
  - `ctrl_busy` is 1 whenever the state is not IDLE.
  - All strobes are single-cycle and combinational from state and inputs.
  - `set_dirty` is 0 whenever `set_data` is 0.
- **Boundary conditions**
  - `ctrl_en` outside IDLE is ignored; `sample_ctrl_inputs` stays 0.
  - `mem_ack` outside WRITE_BACK/ALLOCATE is ignored.
  - `mem_ack` in the first cycle of `mem_en` is legal and completes that access.
  - `mem_en` never drops before `mem_ack` except on reset.

## Timing
- **Reset**
  - While `reset` is high, every output is forced to 0, including the counters with stats enabled.
  - The state becomes IDLE on the next edge.
  - Reset mid-access abandons the access: `mem_en` drops immediately, and the memory must tolerate this.
- **Latency**, with `ctrl_en` sampled at edge 0:
  - Read hit: COMPARE in cycle 1; `ctrl_busy` is low again at cycle 2.
  - Write hit: same as read hit; the data is written at the edge that ends cycle 1.
  - Clean miss: `mem_en` rises in cycle 2. `mem_ack` arrives after N≥1 cycles of `mem_en`, then one refill edge, one COMPARE cycle, then IDLE.
  - Dirty miss: adds the WRITE_BACK handshake before ALLOCATE.
- Back-to-back requests: a new `ctrl_en` is accepted in the first IDLE cycle. The minimum spacing for hits is 2 cycles.

## Configuration
- `CACHE_STATS_EN` defined:
  - Three `COUNTER_SIZE`-bit counters, each saturating at all-ones.
  - `hit_count` +1 on a COMPARE hit that is not a post-refill re-compare. A 1-bit refill flag is set on leaving ALLOCATE and cleared on leaving COMPARE.
  - `miss_count` +1 on a COMPARE miss.
  - `writeback_count` +1 on `mem_ack` in WRITE_BACK.
- `CACHE_STATS_EN` undefined: the counters, the refill flag and their ports are absent. FSM behaviour is identical.

## Test plan
- **Reset mid-ALLOCATE:** assert `reset` during ALLOCATE with `mem_en`=1 → all outputs 0 that cycle, IDLE next edge, `ctrl_busy`=0.
- **Read hit:** `ctrl_en` with `hit`=1, `ctrl_wr_en_d`=0 → `sample_ctrl_inputs` pulse at cycle 0, `ctrl_busy` high in cycle 1 only, no `mem_en`, no strobes; `hit_count`=1.
- **Write hit:** same as read hit with `ctrl_wr_en_d`=1 → `set_data`=`set_dirty`=1 for exactly cycle 1, back to IDLE in cycle 2.
- **Clean read miss, `mem_ack` after 3 cycles:** `mem_en`=1, `mem_wr_en`=0 for 3 cycles, then a single refill cycle with `set_data`, `set_valid`, `set_tag`=1 and `set_dirty`=0 → COMPARE hit → IDLE; `miss_count`=1, `hit_count` unchanged.
- **Dirty write miss:** → WRITE_BACK with `mem_wr_en`=1 until `mem_ack`, then ALLOCATE, refill, and a COMPARE write with `set_dirty`=1; `writeback_count`=1.
- **Ignored inputs:** `ctrl_en` held high through a whole miss and `mem_ack` pulsed in IDLE → no extra `sample_ctrl_inputs` pulse while busy, no state change from the stray ack; stats saturate when preloaded at all-ones.
